// File: rtl/imm_decode_pkg.sv
// Shared types and opcode constants for the registered immediate decode stage.
// Optional CSR-immediate decoding is enabled by defining IMM_DECODE_CSR_IMM_EN.
package imm_decode_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_CSR  = 3'd6
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Entries are stored at the widest supported width; narrower builds use the low bits.
    localparam int unsigned ENTRY_W = 64;

    typedef struct packed {
        logic [ENTRY_W-1:0] imm;
        imm_fmt_e           fmt;
        logic [ENTRY_W-1:0] pc;
        logic               illegal;
    } imm_entry_t;

    localparam imm_entry_t ENTRY_RESET = '{
        imm:     {ENTRY_W{1'b0}},
        fmt:     FMT_NONE,
        pc:      {ENTRY_W{1'b0}},
        illegal: 1'b0
    };

endpackage

// File: rtl/imm_decode_stage_if.sv
// Upstream/downstream valid-ready bundle of the immediate decode stage.
// The slave modport is the stage itself; the master modport is its environment.
interface imm_decode_stage_if #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
);
    import imm_decode_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    imm_fmt_e        out_fmt;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_pc, out_illegal
    );

endinterface

// File: rtl/imm_decode_comb.sv
// Pure combinational RV32/RV64 immediate decoder: format, XLEN immediate, illegal flag.
// Defining IMM_DECODE_CSR_IMM_EN adds zero-extended CSR immediates (FMT_CSR).
module imm_decode_comb
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]  opc_s;
    logic [31:0] imm32_s;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign opc_s = instr[6:0];

    // Immediate is assembled sign-extended to 32 bits, then widened to XLEN.
    always_comb begin
        imm32_s = 32'd0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (opc_s[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opc_s)
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_FENCE: begin
                    imm32_s = {{20{instr[31]}}, instr[31:20]};
                    fmt     = FMT_I;
                end
                OPC_OP_IMM32: begin
                    if (XLEN == 64) begin
                        imm32_s = {{20{instr[31]}}, instr[31:20]};
                        fmt     = FMT_I;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                    fmt     = FMT_S;
                end
                OPC_BRANCH: begin
                    imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                    fmt     = FMT_B;
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm32_s = {instr[31:12], 12'd0};
                    fmt     = FMT_U;
                end
                OPC_JAL: begin
                    imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                    fmt     = FMT_J;
                end
                OPC_OP: begin
                    fmt = FMT_NONE;
                end
                OPC_OP32: begin
                    if (XLEN == 64) begin
                        fmt = FMT_NONE;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_SYSTEM: begin
`ifdef IMM_DECODE_CSR_IMM_EN
                    if (instr[14]) begin
                        imm32_s = {27'd0, instr[19:15]};
                        fmt     = FMT_CSR;
                    end else begin
                        fmt = FMT_NONE;
                    end
`else
                    fmt = FMT_NONE;
`endif
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

    assign imm = sext32(imm32_s);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage: output register plus skid register, valid/ready both sides.
// in_ready depends only on skid occupancy; flush clears both entries. Macro: IMM_DECODE_CSR_IMM_EN.
module imm_decode_stage
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    imm_decode_stage_if.slave  bus
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end
    if (PC_W < 1 || PC_W > ENTRY_W) begin : g_bad_pc_w
        $error("imm_decode_stage: PC_W out of range");
    end

    logic [XLEN-1:0] dec_imm_s;
    imm_fmt_e        dec_fmt_s;
    logic            dec_illegal_s;
    imm_entry_t      dec_entry_s;
    imm_entry_t      or_r, sk_r, or_next_s, sk_next_s;
    logic            or_valid_r, sk_valid_r, in_ready_r;
    logic            or_valid_next_s, sk_valid_next_s;
    logic            accept_s, drain_s, or_free_s;
    logic            unused_bits_s;

    imm_decode_comb #(.XLEN(XLEN)) u_dec (
        .instr   (bus.in_instr),
        .imm     (dec_imm_s),
        .fmt     (dec_fmt_s),
        .illegal (dec_illegal_s)
    );

    // Pack the decoded fields of the incoming instruction into a stage entry.
    always_comb begin
        dec_entry_s         = ENTRY_RESET;
        dec_entry_s.imm     = ENTRY_W'(dec_imm_s);
        dec_entry_s.fmt     = dec_fmt_s;
        dec_entry_s.pc      = ENTRY_W'(bus.in_pc);
        dec_entry_s.illegal = dec_illegal_s;
    end

    assign accept_s  = bus.in_valid & in_ready_r;
    assign drain_s   = or_valid_r & bus.out_ready;
    assign or_free_s = ~or_valid_r | drain_s;

    // Next-state for the output/skid pair; the skid always holds the younger entry.
    always_comb begin
        or_next_s       = or_r;
        or_valid_next_s = or_valid_r;
        sk_next_s       = sk_r;
        sk_valid_next_s = sk_valid_r;
        if (flush) begin
            or_next_s       = ENTRY_RESET;
            or_valid_next_s = 1'b0;
            sk_next_s       = ENTRY_RESET;
            sk_valid_next_s = 1'b0;
        end else if (or_free_s) begin
            if (sk_valid_r) begin
                or_next_s       = sk_r;
                or_valid_next_s = 1'b1;
                if (accept_s) begin
                    sk_next_s       = dec_entry_s;
                    sk_valid_next_s = 1'b1;
                end else begin
                    sk_next_s       = ENTRY_RESET;
                    sk_valid_next_s = 1'b0;
                end
            end else if (accept_s) begin
                or_next_s       = dec_entry_s;
                or_valid_next_s = 1'b1;
            end else begin
                or_next_s       = ENTRY_RESET;
                or_valid_next_s = 1'b0;
            end
        end else if (accept_s) begin
            sk_next_s       = dec_entry_s;
            sk_valid_next_s = 1'b1;
        end else begin
            sk_next_s       = sk_r;
            sk_valid_next_s = sk_valid_r;
        end
    end

    // Stage registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_r       <= ENTRY_RESET;
            sk_r       <= ENTRY_RESET;
            or_valid_r <= 1'b0;
            sk_valid_r <= 1'b0;
            in_ready_r <= 1'b1;
        end else begin
            or_r       <= or_next_s;
            sk_r       <= sk_next_s;
            or_valid_r <= or_valid_next_s;
            sk_valid_r <= sk_valid_next_s;
            in_ready_r <= ~sk_valid_next_s;
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = or_valid_r;
    assign bus.out_imm     = or_r.imm[XLEN-1:0];
    assign bus.out_fmt     = or_r.fmt;
    assign bus.out_pc      = or_r.pc[PC_W-1:0];
    assign bus.out_illegal = or_r.illegal;

    // Upper entry bits are constant zero in narrow builds.
    assign unused_bits_s = ^{or_r.imm, or_r.pc};

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: XLEN=32 and XLEN=64 instances, directed vectors.
// Expected CSR results follow IMM_DECODE_CSR_IMM_EN.
module tb_imm_decode_stage;
    import imm_decode_pkg::*;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] pc;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush32;
    logic flush64;
    int   check_cnt = 0;
    int   fail_cnt  = 0;
    exp_t q32[$];
    exp_t q64[$];
    exp_t mon32_e;
    exp_t mon64_e;

    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32), .PC_W(32)) bus32 ();
    imm_decode_stage_if #(.XLEN(64), .PC_W(64)) bus64 ();

    imm_decode_stage #(.XLEN(32), .PC_W(32)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush32),
        .bus   (bus32)
    );

    imm_decode_stage #(.XLEN(64), .PC_W(64)) u_dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush64),
        .bus   (bus64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        check_cnt++;
        if (act !== req) begin
            fail_cnt++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor for the 32-bit instance: compare the presented entry against the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus32.out_valid !== 1'b0) begin
            if (q32.size() == 0) begin
                chk("out32_unexpected_valid", 64'(bus32.out_valid), 64'd0);
            end else begin
                chk("out32_imm", 64'(bus32.out_imm), q32[0].imm);
                chk("out32_fmt", 64'(bus32.out_fmt), 64'(q32[0].fmt));
                chk("out32_pc", 64'(bus32.out_pc), q32[0].pc);
                chk("out32_illegal", 64'(bus32.out_illegal), 64'(q32[0].ill));
                if (bus32.out_ready) mon32_e = q32.pop_front();
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus64.out_valid !== 1'b0) begin
            if (q64.size() == 0) begin
                chk("out64_unexpected_valid", 64'(bus64.out_valid), 64'd0);
            end else begin
                chk("out64_imm", bus64.out_imm, q64[0].imm);
                chk("out64_fmt", 64'(bus64.out_fmt), 64'(q64[0].fmt));
                chk("out64_pc", bus64.out_pc, q64[0].pc);
                chk("out64_illegal", 64'(bus64.out_illegal), 64'(q64[0].ill));
                if (bus64.out_ready) mon64_e = q64.pop_front();
            end
        end
    end

    task automatic send32(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        exp_t e;
        int   n;
        n = 0;
        bus32.in_valid = 1'b1;
        bus32.in_instr = instr;
        bus32.in_pc    = pc;
        @(negedge clk);
        while (bus32.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus32.in_ready !== 1'b1) begin
            chk("send32_in_ready_timeout", 64'(bus32.in_ready), 64'd1);
        end else begin
            e.imm = imm; e.fmt = fmt; e.pc = 64'(pc); e.ill = ill;
            q32.push_back(e);
        end
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] instr, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
        exp_t e;
        int   n;
        n = 0;
        bus64.in_valid = 1'b1;
        bus64.in_instr = instr;
        bus64.in_pc    = pc;
        @(negedge clk);
        while (bus64.in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus64.in_ready !== 1'b1) begin
            chk("send64_in_ready_timeout", 64'(bus64.in_ready), 64'd1);
        end else begin
            e.imm = imm; e.fmt = fmt; e.pc = pc; e.ill = ill;
            q64.push_back(e);
        end
        @(posedge clk);
        #1;
        bus64.in_valid = 1'b0;
    endtask

    task automatic drain32();
        int n;
        n = 0;
        while (q32.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain32_left", 64'(q32.size()), 64'd0);
    endtask

    task automatic drain64();
        int n;
        n = 0;
        while (q64.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain64_left", 64'(q64.size()), 64'd0);
    endtask

    task automatic chk_idle32(input string tag);
        chk({tag, "_out_valid"}, 64'(bus32.out_valid), 64'd0);
        chk({tag, "_out_imm"}, 64'(bus32.out_imm), 64'd0);
        chk({tag, "_out_fmt"}, 64'(bus32.out_fmt), 64'(FMT_NONE));
        chk({tag, "_out_pc"}, 64'(bus32.out_pc), 64'd0);
        chk({tag, "_out_illegal"}, 64'(bus32.out_illegal), 64'd0);
        chk({tag, "_in_ready"}, 64'(bus32.in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush32 = 1'b0; flush64 = 1'b0;
        bus32.in_valid = 1'b0; bus32.in_instr = 32'd0; bus32.in_pc = 32'd0; bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_instr = 32'd0; bus64.in_pc = 64'd0; bus64.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle32("rst");
        chk("rst64_out_valid", 64'(bus64.out_valid), 64'd0);
        chk("rst64_in_ready", 64'(bus64.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Single-cycle latency after an accept into an empty stage.
        send32(32'hFFF00093, 32'h100, 64'hFFFF_FFFF, FMT_I, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", 64'(bus32.out_valid), 64'd1);
        @(posedge clk); #1;

        send32(32'hFE20AC23, 32'h104, 64'hFFFF_FFF8, FMT_S, 1'b0);
        send32(32'h123450B7, 32'h108, 64'h1234_5000, FMT_U, 1'b0);
        send32(32'h80000097, 32'h10C, 64'h8000_0000, FMT_U, 1'b0);
        send32(32'h7FF02083, 32'h110, 64'h0000_07FF, FMT_I, 1'b0);
        send32(32'h800080E7, 32'h114, 64'hFFFF_F800, FMT_I, 1'b0);
        send32(32'h002081B3, 32'h118, 64'd0, FMT_NONE, 1'b0);
        send32(32'h0000001B, 32'h11C, 64'd0, FMT_NONE, 1'b1);
        send32(32'h0000003B, 32'h120, 64'd0, FMT_NONE, 1'b1);
        send32(32'h00000001, 32'h124, 64'd0, FMT_NONE, 1'b1);
        send32(32'h00000073, 32'h128, 64'd0, FMT_NONE, 1'b0);
        send32(32'h0080006F, 32'h12C, 64'h0000_0008, FMT_J, 1'b0);
`ifdef IMM_DECODE_CSR_IMM_EN
        send32(32'h3401D073, 32'h130, 64'd3, FMT_CSR, 1'b0);
`else
        send32(32'h3401D073, 32'h130, 64'd0, FMT_NONE, 1'b0);
`endif
        send32(32'h34011073, 32'h134, 64'd0, FMT_NONE, 1'b0);
        drain32();

        // Backpressure: second entry lands in the skid, a third waits for in_ready.
        bus32.out_ready = 1'b0;
        send32(32'hFE000EE3, 32'h200, 64'hFFFF_FFFC, FMT_B, 1'b0);
        send32(32'h0080006F, 32'h204, 64'h0000_0008, FMT_J, 1'b0);
        @(negedge clk);
        chk("bp_in_ready", 64'(bus32.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus32.out_valid), 64'd1);
        @(posedge clk); #1;
        fork
            send32(32'hFFF00093, 32'h208, 64'hFFFF_FFFF, FMT_I, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus32.out_ready = 1'b1;
            end
        join
        drain32();
        @(negedge clk);
        chk("bp_in_ready_back", 64'(bus32.in_ready), 64'd1);
        @(posedge clk); #1;

        // Flush while the output is held and an accept happens in the same cycle.
        bus32.out_ready = 1'b0;
        send32(32'h00500093, 32'h300, 64'd5, FMT_I, 1'b0);
        bus32.in_valid = 1'b1; bus32.in_instr = 32'h00700093; bus32.in_pc = 32'h304;
        flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0; bus32.in_valid = 1'b0;
        q32.delete();
        @(negedge clk);
        chk_idle32("flush1");
        @(posedge clk); #1;

        // Flush with both entries full and in_valid high.
        send32(32'h00500093, 32'h310, 64'd5, FMT_I, 1'b0);
        send32(32'h00600093, 32'h314, 64'd6, FMT_I, 1'b0);
        bus32.in_valid = 1'b1; bus32.in_instr = 32'h00700093; bus32.in_pc = 32'h318;
        flush32 = 1'b1;
        @(posedge clk); #1;
        flush32 = 1'b0; bus32.in_valid = 1'b0;
        q32.delete();
        @(negedge clk);
        chk_idle32("flush2");
        bus32.out_ready = 1'b1;
        repeat (5) @(posedge clk); #1;
        send32(32'h00800093, 32'h31C, 64'd8, FMT_I, 1'b0);
        drain32();

        // Asynchronous reset between clock edges with both entries full.
        bus32.out_ready = 1'b0;
        send32(32'h00500093, 32'h400, 64'd5, FMT_I, 1'b0);
        send32(32'h00600093, 32'h404, 64'd6, FMT_I, 1'b0);
        #2;
        rst_n = 1'b0;
        q32.delete();
        #1;
        chk_idle32("async_rst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        bus32.out_ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        send32(32'hFFF00093, 32'h408, 64'hFFFF_FFFF, FMT_I, 1'b0);
        drain32();

        // 64-bit instance.
        send64(32'hFFF00093, 64'h1_0000_0040, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
        send64(32'h800000B7, 64'h1_0000_0044, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
        send64(32'h123450B7, 64'h1_0000_0048, 64'h0000_0000_1234_5000, FMT_U, 1'b0);
        send64(32'hFFF0009B, 64'h1_0000_004C, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
        send64(32'h0000003B, 64'h1_0000_0050, 64'd0, FMT_NONE, 1'b0);
        send64(32'hFE000EE3, 64'h1_0000_0054, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0);
        send64(32'h00000013, 64'h1_0000_0058, 64'd0, FMT_I, 1'b0);
        send64(32'h0000007F, 64'h1_0000_005C, 64'd0, FMT_NONE, 1'b1);
        drain64();

        repeat (3) @(posedge clk); #1;
        chk("final_q32_empty", 64'(q32.size()), 64'd0);
        chk("final_q64_empty", 64'(q64.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end

endmodule
